mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 16 +
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, completion and RAM bus signals between two cores, the arbiter and the RAM.
interface mem_arbiter_if;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [31:0]      load, ramaddr, ramstore, ramload;
  logic             ramREN, ramWEN, ram_done, gnt_core, bus_err;
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ram_done,
    input  iwait, dwait, load, ramREN, ramWEN, ramaddr, ramstore, gnt_core, bus_err
  );
  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ram_done,
    output iwait, dwait, load, ramREN, ramWEN, ramaddr, ramstore, gnt_core, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-core round-robin arbiter onto a single RAM port with an access timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state_q, state_d;
  logic        last_q, last_d, core_q, core_d, dside_q, dside_d, err_q, err_d;
  logic        ren_q, ren_d, wen_q, wen_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, store_q, store_d;
  logic [1:0]  elig;
  logic        pick, finish, done;
  always_comb begin
    elig    = bus.iREN | bus.dREN | bus.dWEN;
    pick    = &elig ? ~last_q : elig[1];
    finish  = state_q == ACCESS && (bus.ram_done || cnt_q == 8'(TIMEOUT - 1));
    state_d = state_q;
    last_d  = last_q;
    core_d  = core_q;
    dside_d = dside_q;
    err_d   = err_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    store_d = store_q;
    if (state_q == IDLE && |elig) begin
      state_d = ACCESS;
      core_d  = pick;
      wen_d   = bus.dWEN[pick];
      ren_d   = ~bus.dWEN[pick];
      dside_d = bus.dWEN[pick] | bus.dREN[pick];
      addr_d  = dside_d ? bus.daddr[pick] : bus.iaddr[pick];
      store_d = bus.dstore[pick];
      cnt_d   = '0;
    end else if (finish) begin
      state_d = IDLE;
      last_d  = core_q;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      err_d   = err_q | ~bus.ram_done;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
  // A reset cycle never delivers a completion, even if the RAM reports done.
  assign done         = finish & ~RST;
  assign bus.iwait    = ~(2'(done & ~dside_q) << core_q);
  assign bus.dwait    = ~(2'(done & dside_q) << core_q);
  assign bus.load     = bus.ramload;
  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.gnt_core = core_q;
  assign bus.bus_err  = err_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      core_q  <= 1'b0;
      dside_q <= 1'b0;
      err_q   <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      core_q  <= core_d;
      dside_q <= dside_d;
      err_q   <= err_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;
  logic CLK = 1'b0;
  logic RST;
  mem_arbiter_if bus ();
  mem_arbiter #(.TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  // Model: one outstanding transaction record plus the arbitration history.
  bit          m_busy, m_core, m_write, m_dside, m_last, m_err, m_gnt;
  int          m_age;
  logic [31:0] m_addr, m_store;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_core = 0; m_write = 0; m_dside = 0; m_last = 1; m_err = 0; m_gnt = 0;
    m_age = 0; m_addr = '0; m_store = '0;
  endtask

  task automatic drive(input logic [1:0] i, input logic [1:0] d, input logic [1:0] w, input logic done);
    bus.iREN = i; bus.dREN = d; bus.dWEN = w; bus.ram_done = done;
  endtask

  // Inputs are set before the call; checks happen at the falling edge, model advances with the rising edge.
  task automatic step(input bit check);
    bit         fin, c;
    logic [1:0] ew_i, ew_d, el;
    @(negedge CLK);
    fin  = m_busy && !RST && (bus.ram_done || m_age == TO - 1);
    ew_i = 2'b11;
    ew_d = 2'b11;
    if (fin) begin
      if (m_dside) ew_d[m_core] = 1'b0;
      else         ew_i[m_core] = 1'b0;
    end
    if (check) begin
      chk("ramREN",   bus.ramREN,   m_busy && !m_write);
      chk("ramWEN",   bus.ramWEN,   m_busy && m_write);
      chk("ramaddr",  bus.ramaddr,  m_addr);
      chk("ramstore", bus.ramstore, m_store);
      chk("gnt_core", bus.gnt_core, m_gnt);
      chk("bus_err",  bus.bus_err,  m_err);
      chk("iwait",    bus.iwait,    ew_i);
      chk("dwait",    bus.dwait,    ew_d);
      chk("load",     bus.load,     bus.ramload);
    end
    if (RST) model_reset();
    else if (m_busy) begin
      if (fin) begin
        m_busy = 0;
        m_last = m_core;
        if (!bus.ram_done) m_err = 1;
      end else m_age++;
    end else begin
      el = bus.iREN | bus.dREN | bus.dWEN;
      if (el != 2'b00) begin
        c       = (el == 2'b11) ? !m_last : el[1];
        m_busy  = 1;
        m_core  = c;
        m_gnt   = c;
        m_write = bus.dWEN[c];
        m_dside = bus.dWEN[c] | bus.dREN[c];
        m_addr  = m_dside ? bus.daddr[c] : bus.iaddr[c];
        m_store = bus.dstore[c];
        m_age   = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int pct;
    model_reset();
    RST = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
    step(0);
    RST = 1'b0;
    step(1);
    // Single instruction read with minimum latency.
    bus.iaddr[0] = 32'h40;
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    step(1);
    bus.ramload = 32'hDEADBEEF;
    drive(2'b00, 2'b00, 2'b00, 1'b1);
    step(1);
    chk("last_iwait0", bus.iwait, 2'b11);
    // Both cores reading continuously: grants alternate.
    bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h200;
    drive(2'b00, 2'b11, 2'b00, 1'b1);
    repeat (8) step(1);
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    // Core 1 write takes priority over its instruction fetch.
    bus.daddr[1] = 32'h80; bus.dstore[1] = 32'h1234; bus.iaddr[1] = 32'h300;
    drive(2'b10, 2'b00, 2'b10, 1'b0);
    step(1);
    step(1);
    bus.ram_done = 1'b1;
    step(1);
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    step(1);
    bus.ram_done = 1'b1;
    step(1);
    // Timeout with no ram_done, then a normal access afterwards.
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    repeat (7) step(1);
    drive(2'b00, 2'b01, 2'b00, 1'b1);
    repeat (3) step(1);
    // Reset in the middle of an access, then a tie goes to core 0.
    drive(2'b00, 2'b11, 2'b00, 1'b0);
    step(1);
    step(1);
    RST = 1'b1;
    bus.ram_done = 1'b1;
    step(1);
    RST = 1'b0;
    bus.ram_done = 1'b0;
    step(1);
    step(1);
    // Randomized traffic with phases of prompt and sluggish RAM.
    for (int n = 0; n < 4000; n++) begin
      pct = ((n / 200) % 2 == 0) ? 70 : 8;
      drive(2'($urandom), 2'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
            $urandom_range(0, 99) < pct);
      bus.iaddr[0] = $urandom; bus.iaddr[1] = $urandom;
      bus.daddr[0] = $urandom; bus.daddr[1] = $urandom;
      bus.dstore[0] = $urandom; bus.dstore[1] = $urandom;
      bus.ramload = $urandom;
      RST = ($urandom_range(0, 299) == 0);
      step(1);
    end
    RST = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
